// File: rtl/sound_seq_pkg.sv
// Shared definitions for the bus-programmable sound sequencer: register map,
// status layout, FSM encoding and the packed note entry kept in the FIFO.
package sound_seq_pkg;

    localparam logic [1:0] REG_FREQ_L = 2'd0;
    localparam logic [1:0] REG_FREQ_H = 2'd1;
    localparam logic [1:0] REG_LEVEL  = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int STAT_BUSY  = 7;
    localparam int STAT_FULL  = 6;
    localparam int STAT_EMPTY = 5;
    localparam int STAT_OVF   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] freq;   // half-period minus one, in ticks; 0 = rest
        logic [7:0]  level;
        logic [7:0]  dur;    // note length in ms
    } note_t;

    function automatic logic [3:0] sat4(input logic [7:0] n);
        return (n > 8'd15) ? 4'hF : n[3:0];
    endfunction

endpackage

// File: rtl/ip_sound_fifo.sv
// Small synchronous FIFO for queued notes; a push into a full queue is dropped
// and flush takes priority over push and pop.
module ip_sound_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      data_in,
    output logic [WIDTH-1:0]      data_out,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full     = count[DEPTH_LOG2];
    assign empty    = (count == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign data_out = mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and count need a known value.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ip_sound_sequencer.sv
// Bus-programmable tone scheduler: notes queued over I/O ports are played
// back-to-back as a square-wave level for the PWM, timed by a 1 MHz tick.
module ip_sound_sequencer
    import sound_seq_pkg::*;
#(
    parameter logic [7:0] io_address      = 8'h10,
    parameter int         FIFO_DEPTH_LOG2 = 2,
    parameter int         TICK_DIV        = 64,
    parameter int         MS_TICKS        = 1000
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] bus_address,
    input  logic        bus_io,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [7:0]  bus_write_data,
    output logic [7:0]  bus_read_data,
    output logic        bus_read_ready,
    output logic        tick_1mhz,
    output logic [7:0]  sound_level,
    output logic        busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MW = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_RELOAD = PW'(TICK_DIV - 1);
    localparam logic [MW-1:0] MS_RELOAD    = MW'(MS_TICKS - 1);

    logic [PW-1:0]              presc;
    logic [7:0]                 offset;
    logic                       wr, push, stop, rd_status;
    logic [15:0]                freq_stage;
    logic [7:0]                 level_stage;
    logic                       overflow;
    note_t                      head;
    logic                       fifo_full, fifo_empty, pop;
    logic [FIFO_DEPTH_LOG2:0]   fifo_count;
    state_t                     state, next_state;
    logic [15:0]                cur_freq, div_cnt;
    logic [7:0]                 cur_level, dur_cnt;
    logic [MW-1:0]              ms_cnt;
    logic                       note_end;
    logic [7:0]                 status;
    logic                       unused_addr_hi;

    assign unused_addr_hi = ^bus_address[15:8];

    // Wrapping subtraction lets the four-port window sit at any base address.
    assign offset    = bus_address[7:0] - io_address;
    assign wr        = bus_io && bus_write && (offset < 8'd4);
    assign push      = wr && (offset[1:0] == REG_CTRL) && (bus_write_data != 8'd0);
    assign stop      = wr && (offset[1:0] == REG_CTRL) && (bus_write_data == 8'd0);
    assign rd_status = bus_io && bus_read && (offset == {6'd0, REG_CTRL});

    assign busy     = (state == S_PLAY);
    assign pop      = (state == S_LOAD) && !stop;
    assign note_end = (state == S_PLAY) && tick_1mhz && (ms_cnt == '0) && (dur_cnt == 8'd1);

    always_comb begin
        status                      = '0;
        status[STAT_BUSY]           = busy;
        status[STAT_FULL]           = fifo_full;
        status[STAT_EMPTY]          = fifo_empty;
        status[STAT_OVF]            = overflow;
        status[3:0]                 = sat4(8'(fifo_count));
    end

    ip_sound_fifo #(
        .WIDTH      (32),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .n_reset  (n_reset),
        .push     (push),
        .pop      (pop),
        .flush    (stop),
        .data_in  ({freq_stage, level_stage, bus_write_data}),
        .data_out (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            presc     <= '0;
            tick_1mhz <= 1'b0;
        end else begin
            tick_1mhz <= (presc == '0);
            presc     <= (presc == '0) ? PRESC_RELOAD : presc - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            freq_stage     <= '0;
            level_stage    <= '0;
            overflow       <= 1'b0;
            bus_read_ready <= 1'b0;
            bus_read_data  <= '0;
        end else begin
            if (wr && offset[1:0] == REG_FREQ_L) freq_stage[7:0]  <= bus_write_data;
            if (wr && offset[1:0] == REG_FREQ_H) freq_stage[15:8] <= bus_write_data;
            if (wr && offset[1:0] == REG_LEVEL)  level_stage      <= bus_write_data;
            if (push && fifo_full)           overflow <= 1'b1;
            else if (stop || rd_status)      overflow <= 1'b0;
            bus_read_ready <= rd_status;
            bus_read_data  <= rd_status ? status : 8'd0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= S_IDLE;
        else          state <= next_state;
    end

    // NOTE: next_state gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (!fifo_empty) next_state = S_LOAD;
            S_LOAD:  next_state = S_PLAY;
            S_PLAY:  if (note_end) next_state = fifo_empty ? S_IDLE : S_LOAD;
            default: next_state = S_IDLE;
        endcase
        if (stop) next_state = S_IDLE;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cur_freq    <= '0;
            cur_level   <= '0;
            div_cnt     <= '0;
            ms_cnt      <= '0;
            dur_cnt     <= '0;
            sound_level <= '0;
        end else if (stop) begin
            sound_level <= '0;
        end else if (state == S_LOAD) begin
            cur_freq    <= head.freq;
            cur_level   <= head.level;
            div_cnt     <= head.freq;
            ms_cnt      <= MS_RELOAD;
            dur_cnt     <= head.dur;
            sound_level <= (head.freq == 16'd0) ? 8'd0 : head.level;
        end else if (state == S_PLAY && tick_1mhz) begin
            if (ms_cnt == '0) begin
                ms_cnt  <= MS_RELOAD;
                dur_cnt <= dur_cnt - 1'b1;
            end else begin
                ms_cnt  <= ms_cnt - 1'b1;
            end
            if (div_cnt == 16'd0) begin
                div_cnt <= cur_freq;
                if (cur_freq != 16'd0) sound_level <= (sound_level == 8'd0) ? cur_level : 8'd0;
            end else begin
                div_cnt <= div_cnt - 1'b1;
            end
            if (note_end && fifo_empty) sound_level <= '0;
        end
    end

endmodule

// File: tb/tb_ip_sound_sequencer.sv
// Self-checking bench for ip_sound_sequencer with a fast tick (TICK_DIV=4) and
// short ms (MS_TICKS=10); status reads are scored through an expectation queue.
module tb_ip_sound_sequencer;

    localparam int TICK_DIV = 4;
    localparam int MS_TICKS = 10;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [15:0] bus_address = '0;
    logic        bus_io = 1'b0;
    logic        bus_write = 1'b0;
    logic        bus_read = 1'b0;
    logic [7:0]  bus_write_data = '0;
    logic [7:0]  bus_read_data;
    logic        bus_read_ready;
    logic        tick_1mhz;
    logic [7:0]  sound_level;
    logic        busy;

    int          n_pass = 0;
    int          n_checks = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;

    typedef enum logic [1:0] {OP_WR, OP_RD, OP_WAIT} op_kind_t;
    typedef struct {
        op_kind_t   kind;
        logic [1:0] off;
        logic [7:0] data;
        logic       expect_ready;
        logic [7:0] exp_status;
    } vec_t;
    vec_t vecs[14];

    always #5 clk = ~clk;

    ip_sound_sequencer #(
        .io_address      (8'h10),
        .FIFO_DEPTH_LOG2 (2),
        .TICK_DIV        (TICK_DIV),
        .MS_TICKS        (MS_TICKS)
    ) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .bus_address    (bus_address),
        .bus_io         (bus_io),
        .bus_write      (bus_write),
        .bus_read       (bus_read),
        .bus_write_data (bus_write_data),
        .bus_read_data  (bus_read_data),
        .bus_read_ready (bus_read_ready),
        .tick_1mhz      (tick_1mhz),
        .sound_level    (sound_level),
        .busy           (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    // Tasks start and end on a falling edge.
    task automatic bus_wr(input logic [1:0] off, input logic [7:0] data);
        bus_address = 16'h0010 + 16'(off);
        bus_io = 1'b1; bus_write = 1'b1; bus_write_data = data;
        @(negedge clk);
        bus_io = 1'b0; bus_write = 1'b0; bus_write_data = '0;
    endtask

    task automatic bus_rd(input logic [1:0] off, input logic exp_ready, input logic [7:0] exp);
        bus_address = 16'h0010 + 16'(off);
        bus_io = 1'b1; bus_read = 1'b1;
        if (exp_ready) exp_q.push_back(exp);
        @(negedge clk);
        bus_io = 1'b0; bus_read = 1'b0;
    endtask

    task automatic wait_busy(input logic want, input int bound, output int cycles);
        cycles = 0;
        while (busy !== want && cycles < bound) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    always @(negedge clk) begin
        if (n_reset && bus_read_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("status_read", bus_read_data, mon_exp);
            end
        end
    end

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int          c;
        int          cyc;
        int          gap;
        logic [7:0]  prev;
        logic        any_level;
        logic        any_busy;
        int          tr[$];

        vecs[0]  = '{OP_WR,   2'd0, 8'd5,   1'b0, 8'h00};
        vecs[1]  = '{OP_WR,   2'd1, 8'd0,   1'b0, 8'h00};
        vecs[2]  = '{OP_WR,   2'd2, 8'h40,  1'b0, 8'h00};
        vecs[3]  = '{OP_WR,   2'd3, 8'd200, 1'b0, 8'h00};
        vecs[4]  = '{OP_WAIT, 2'd0, 8'd4,   1'b0, 8'h00};
        vecs[5]  = '{OP_RD,   2'd3, 8'd0,   1'b1, 8'hA0};
        vecs[6]  = '{OP_WR,   2'd3, 8'd1,   1'b0, 8'h00};
        vecs[7]  = '{OP_WR,   2'd3, 8'd2,   1'b0, 8'h00};
        vecs[8]  = '{OP_WR,   2'd3, 8'd3,   1'b0, 8'h00};
        vecs[9]  = '{OP_WR,   2'd3, 8'd4,   1'b0, 8'h00};
        vecs[10] = '{OP_WR,   2'd3, 8'd5,   1'b0, 8'h00};
        vecs[11] = '{OP_RD,   2'd3, 8'd0,   1'b1, 8'hD4};
        vecs[12] = '{OP_RD,   2'd3, 8'd0,   1'b1, 8'hC4};
        vecs[13] = '{OP_RD,   2'd1, 8'd0,   1'b0, 8'h00};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sound_level", sound_level, 8'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_tick", tick_1mhz, 1'b0);
        check("rst_ready", bus_read_ready, 1'b0);
        check("rst_rdata", bus_read_data, 8'd0);
        n_reset = 1'b1;
        bus_rd(2'd3, 1'b1, 8'h20);

        // Tick period and width
        c = 0;
        while (tick_1mhz !== 1'b1 && c < 8) begin @(negedge clk); c++; end
        check("tick_seen", tick_1mhz, 1'b1);
        @(negedge clk);
        check("tick_width", tick_1mhz, 1'b0);
        cyc = 1;
        while (tick_1mhz !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        check("tick_period", cyc, TICK_DIV);

        // Status read timing and unclaimed offset
        bus_address = 16'h0013; bus_io = 1'b1; bus_read = 1'b1;
        exp_q.push_back(8'h20);
        @(negedge clk);
        bus_io = 1'b0; bus_read = 1'b0;
        check("rd_ready_t1", bus_read_ready, 1'b1);
        @(negedge clk);
        check("rd_ready_t2", bus_read_ready, 1'b0);
        check("rd_data_idle", bus_read_data, 8'd0);
        bus_rd(2'd1, 1'b0, 8'h00);
        check("rd_off1_t1", bus_read_ready, 1'b0);
        @(negedge clk);
        check("rd_off1_t2", bus_read_ready, 1'b0);

        // Single note: half-period 3 ticks, length 10 ticks
        bus_wr(2'd0, 8'd2);
        bus_wr(2'd1, 8'd0);
        bus_wr(2'd2, 8'hC0);
        bus_wr(2'd3, 8'd1);
        wait_busy(1'b1, 6, c);
        check("single_busy", busy, 1'b1);
        check_range("single_start_latency", c, 1, 3);
        check("single_first_level", sound_level, 8'hC0);
        cyc = 0; prev = sound_level; tr.delete();
        while (busy === 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1 && sound_level !== prev) begin
                tr.push_back(cyc);
                prev = sound_level;
            end
        end
        check("single_toggles", tr.size(), 3);
        if (tr.size() >= 3) begin
            check("single_half_period_a", tr[1] - tr[0], 3 * TICK_DIV);
            check("single_half_period_b", tr[2] - tr[1], 3 * TICK_DIV);
        end
        check_range("single_length", cyc, 9 * TICK_DIV, 11 * TICK_DIV);
        check("single_end_level", sound_level, 8'd0);
        check("single_end_busy", busy, 1'b0);
        bus_rd(2'd3, 1'b1, 8'h20);

        // Gapless queue: toned 1 ms note then a 2 ms rest
        bus_wr(2'd0, 8'd1);
        bus_wr(2'd2, 8'hC0);
        bus_wr(2'd3, 8'd1);
        bus_wr(2'd0, 8'd0);
        bus_wr(2'd3, 8'd2);
        wait_busy(1'b1, 6, c);
        check("gapless_first_busy", busy, 1'b1);
        wait_busy(1'b0, 60, c);
        check("gapless_first_end", busy, 1'b0);
        gap = 0;
        while (busy !== 1'b1 && gap < 10) begin @(negedge clk); gap++; end
        check("gapless_gap", gap, 1);
        cyc = 0; any_level = (sound_level != 8'd0);
        while (busy === 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (sound_level != 8'd0) any_level = 1'b1;
        end
        check("gapless_rest_silent", any_level, 1'b0);
        check_range("gapless_rest_length", cyc, 19 * MS_TICKS * TICK_DIV / 10, 21 * MS_TICKS * TICK_DIV / 10);

        // Overflow and status clearing, table-driven
        foreach (vecs[i]) begin
            case (vecs[i].kind)
                OP_WR:   bus_wr(vecs[i].off, vecs[i].data);
                OP_RD:   bus_rd(vecs[i].off, vecs[i].expect_ready, vecs[i].exp_status);
                default: repeat (int'(vecs[i].data)) @(negedge clk);
            endcase
        end

        // STOP mid-note while the queue is full
        c = 0;
        while (sound_level == 8'd0 && c < 60) begin @(negedge clk); c++; end
        check("stop_pre_level", sound_level, 8'h40);
        bus_wr(2'd3, 8'd0);
        check("stop_level", sound_level, 8'd0);
        check("stop_busy", busy, 1'b0);
        bus_rd(2'd3, 1'b1, 8'h20);
        any_busy = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (busy === 1'b1) any_busy = 1'b1;
        end
        check("stop_no_replay", any_busy, 1'b0);

        // Asynchronous reset mid-note
        bus_wr(2'd0, 8'd3);
        bus_wr(2'd2, 8'h55);
        bus_wr(2'd3, 8'd50);
        bus_wr(2'd3, 8'd50);
        wait_busy(1'b1, 6, c);
        check("areset_pre_busy", busy, 1'b1);
        check("areset_pre_level", sound_level, 8'h55);
        #2;
        n_reset = 1'b0;
        #1;
        check("areset_level", sound_level, 8'd0);
        check("areset_busy", busy, 1'b0);
        check("areset_tick", tick_1mhz, 1'b0);
        check("areset_ready", bus_read_ready, 1'b0);
        check("areset_rdata", bus_read_data, 8'd0);
        @(negedge clk);
        n_reset = 1'b1;
        bus_rd(2'd3, 1'b1, 8'h20);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
